// File: rtl/instr_stream_encoder.sv
// MIPS instruction stream encoder: encodes R/I/J field requests, buffers them, writes to imem.
// Optional build macro ENCODER_DELAY_SLOT_NOP_EN appends a NOP after each BEQ/BNE/J/JAL word.
module instr_stream_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_RESET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef ENCODER_DELAY_SLOT_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q, wcount_q;
    logic              done_q, err_q, nop_pending_q;

    logic        full, empty, accept, push, pop, nop_push;
    logic        supported, is_branch;
    logic [31:0] enc_word, push_word;

    // Field packing and opcode legality, evaluated on the request as presented
    always_comb begin
        enc_word  = 32'h0;
        supported = 1'b0;
        is_branch = 1'b0;
        case (in_opcode)
            6'h00: begin
                enc_word  = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
                supported = 1'b1;
            end
            6'h08, 6'h0c, 6'h0d, 6'h23, 6'h2b: begin
                enc_word  = {in_opcode, in_rs, in_rt, in_imm};
                supported = 1'b1;
            end
            6'h0f: begin
                enc_word  = {in_opcode, 5'd0, in_rt, in_imm};
                supported = 1'b1;
            end
            6'h04, 6'h05: begin
                enc_word  = {in_opcode, in_rs, in_rt, in_imm};
                supported = 1'b1;
                is_branch = 1'b1;
            end
            6'h02, 6'h03: begin
                enc_word  = {in_opcode, in_target};
                supported = 1'b1;
                is_branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = (state_q == S_RUN) && !full && !nop_pending_q;
    assign accept    = in_valid && in_ready;
    assign nop_push  = nop_pending_q && !full;
    assign push      = (accept && supported) || nop_push;
    assign push_word = nop_push ? 32'h0 : enc_word;
    assign mem_valid = (state_q != S_IDLE) && !empty;
    assign pop       = mem_valid && mem_ready;

    assign mem_wdata  = mem_valid ? fifo_q[rd_ptr_q] : 32'h0;
    assign mem_addr   = addr_q;
    assign word_count = wcount_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

    // Control FSM, FIFO bookkeeping and write-address tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            addr_q        <= ADDR_W'(BASE_RESET);
            wcount_q      <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            nop_pending_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= accept && !supported;

            if (push) begin
                fifo_q[wr_ptr_q] <= push_word;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                addr_q   <= addr_q + ADDR_W'(4);
                wcount_q <= wcount_q + ADDR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

            if (nop_push) begin
                nop_pending_q <= 1'b0;
            end else if (NOP_EN && accept && supported && is_branch) begin
                nop_pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        addr_q   <= {base_addr[ADDR_W-1:2], 2'b00};
                        wcount_q <= '0;
                    end
                end
                S_RUN: begin
                    if (accept && in_last) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (empty && !nop_pending_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: vector table of single-instruction programs plus
// hand-written sequences for backpressure, wrap, errors and mid-stream reset.
module tb_instr_stream_encoder;
    localparam int unsigned ADDR_W = 10;
`ifdef ENCODER_DELAY_SLOT_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_ready, in_last;
    logic [ADDR_W-1:0] base_addr, mem_addr, word_count;
    logic [5:0]        in_opcode, in_funct;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_valid, mem_ready, busy, done, err;
    logic [31:0]       mem_wdata;

    instr_stream_encoder #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .BASE_RESET(0)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        ok;
        logic        br;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    logic [ADDR_W-1:0] wq_addr [$];
    logic [31:0]       wq_data [$];

    // Write and error recorder
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_valid && mem_ready) begin
                wq_addr.push_back(mem_addr);
                wq_data.push_back(mem_wdata);
            end
            if (err) err_cnt++;
        end
    end

    function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [25:0] tgt,
                                input logic ok, input logic br, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.fn = fn;
        v.imm = imm; v.tgt = tgt; v.ok = ok; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    // Present one request; call at posedge+1, returns at posedge+1 after the accepting edge
    task automatic send(input vec_t v, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_last = last;
        in_opcode = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
        in_funct = v.fn; in_imm = v.imm; in_target = v.tgt;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        check(name, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        logic [ADDR_W-1:0] b, ea;
        int nexp, e0;
        vec_t addi, rtyp, jmp, bad, lw, ori;

        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0;
        in_imm = '0; in_target = '0; mem_ready = 1'b1;

        vt[0]  = mk(6'h08, 5'd1,  5'd2,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0, 1, 0, 32'h20220005);
        vt[1]  = mk(6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 16'h0000, 26'h0, 1, 0, 32'h00221820);
        vt[2]  = mk(6'h02, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h0000010, 1, 1, 32'h08000010);
        vt[3]  = mk(6'h23, 5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 16'hFFFC, 26'h0, 1, 0, 32'h8FA8FFFC);
        vt[4]  = mk(6'h0f, 5'd7,  5'd4,  5'd0,  5'd0, 6'h00, 16'h1234, 26'h0, 1, 0, 32'h3C041234);
        vt[5]  = mk(6'h2b, 5'd3,  5'd5,  5'd0,  5'd0, 6'h00, 16'h0010, 26'h0, 1, 0, 32'hAC650010);
        vt[6]  = mk(6'h04, 5'd1,  5'd2,  5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h0, 1, 1, 32'h1022FFFF);
        vt[7]  = mk(6'h0d, 5'd31, 5'd31, 5'd0,  5'd0, 6'h00, 16'hABCD, 26'h0, 1, 0, 32'h37FFABCD);
        vt[8]  = mk(6'h00, 5'd0,  5'd9,  5'd10, 5'd4, 6'h00, 16'h0000, 26'h0, 1, 0, 32'h00095100);
        vt[9]  = mk(6'h03, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 1, 1, 32'h0FFFFFFF);
        vt[10] = mk(6'h3F, 5'd1,  5'd2,  5'd3,  5'd0, 6'h00, 16'h0001, 26'h0, 0, 0, 32'h00000000);
        vt[11] = mk(6'h0c, 5'd2,  5'd3,  5'd0,  5'd0, 6'h00, 16'h00FF, 26'h0, 1, 0, 32'h304300FF);
        vt[12] = mk(6'h05, 5'd4,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0002, 26'h0, 1, 1, 32'h14800002);

        tick(); tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wcount", 32'(word_count), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single-instruction programs from the table
        for (int i = 0; i < NV; i++) begin
            b = ADDR_W'(32'h100 + 32'(i * 8) + 32'(i % 4));
            ea = {b[ADDR_W-1:2], 2'b00};
            clear_q();
            e0 = err_cnt;
            do_start(b);
            send(vt[i], 1'b1);
            @(negedge clk);
            if (vt[i].ok) begin
                check($sformatf("v%0d_lat_valid", i), 32'(mem_valid), 32'd1);
                check($sformatf("v%0d_lat_wdata", i), mem_wdata, vt[i].exp);
            end else begin
                check($sformatf("v%0d_err", i), 32'(err), 32'd1);
                check($sformatf("v%0d_nowrite", i), 32'(mem_valid), 32'd0);
            end
            wait_done($sformatf("v%0d_done", i));
            nexp = vt[i].ok ? ((vt[i].br && NOP_EN) ? 2 : 1) : 0;
            check($sformatf("v%0d_nwrites", i), 32'(wq_data.size()), 32'(nexp));
            check($sformatf("v%0d_errcnt", i), 32'(err_cnt - e0), vt[i].ok ? 32'd0 : 32'd1);
            if (nexp > 0 && wq_data.size() > 0) begin
                check($sformatf("v%0d_data", i), wq_data[0], vt[i].exp);
                check($sformatf("v%0d_addr", i), 32'(wq_addr[0]), 32'(ea));
            end
            if (nexp == 2 && wq_data.size() > 1) begin
                check($sformatf("v%0d_nop", i), wq_data[1], 32'h0);
                check($sformatf("v%0d_nop_addr", i), 32'(wq_addr[1]), 32'(ADDR_W'(ea + 4)));
            end
            check($sformatf("v%0d_wcount", i), 32'(word_count), 32'(nexp));
            tick();
        end

        // Two-word program; a start pulse while running must be ignored
        rtyp = vt[1]; jmp = vt[2];
        clear_q();
        do_start(10'h000);
        send(rtyp, 1'b0);
        start = 1'b1; base_addr = 10'h200;
        tick();
        start = 1'b0;
        send(jmp, 1'b1);
        @(negedge clk);
        check("seqA_ready_drop", 32'(in_ready), 32'd0);
        wait_done("seqA_done");
        nexp = NOP_EN ? 3 : 2;
        check("seqA_nwrites", 32'(wq_data.size()), 32'(nexp));
        if (wq_data.size() >= 2) begin
            check("seqA_d0", wq_data[0], 32'h00221820);
            check("seqA_a0", 32'(wq_addr[0]), 32'h000);
            check("seqA_d1", wq_data[1], 32'h08000010);
            check("seqA_a1", 32'(wq_addr[1]), 32'h004);
        end
        if (NOP_EN && wq_data.size() >= 3) begin
            check("seqA_d2", wq_data[2], 32'h0);
            check("seqA_a2", 32'(wq_addr[2]), 32'h008);
        end
        check("seqA_wcount", 32'(word_count), 32'(nexp));
        tick();

        // Backpressure: FIFO fills after four accepts, head held stable
        addi = vt[0];
        clear_q();
        mem_ready = 1'b0;
        do_start(10'h040);
        for (int k = 0; k < 4; k++) begin
            addi.imm = 16'(k);
            send(addi, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("seqB_full_ready", 32'(in_ready), 32'd0);
            check("seqB_hold_valid", 32'(mem_valid), 32'd1);
            check("seqB_hold_wdata", mem_wdata, 32'h20220000);
            check("seqB_hold_addr", 32'(mem_addr), 32'h040);
        end
        tick();
        mem_ready = 1'b1;
        addi.imm = 16'd4;
        send(addi, 1'b1);
        wait_done("seqB_done");
        check("seqB_nwrites", 32'(wq_data.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wq_data.size()) begin
                check($sformatf("seqB_d%0d", k), wq_data[k], 32'h20220000 | 32'(k));
                check($sformatf("seqB_a%0d", k), 32'(wq_addr[k]), 32'h040 + 32'(4 * k));
            end
        end
        check("seqB_wcount", 32'(word_count), 32'd5);
        tick();

        // Unsupported opcode mid-program is dropped but counted as accepted
        bad = vt[10]; lw = vt[3];
        addi = vt[0]; addi.imm = 16'h0001;
        clear_q();
        e0 = err_cnt;
        do_start(10'h080);
        send(addi, 1'b0);
        send(bad, 1'b0);
        send(lw, 1'b1);
        wait_done("seqC_done");
        check("seqC_errcnt", 32'(err_cnt - e0), 32'd1);
        check("seqC_nwrites", 32'(wq_data.size()), 32'd2);
        if (wq_data.size() >= 2) begin
            check("seqC_d0", wq_data[0], 32'h20220001);
            check("seqC_d1", wq_data[1], 32'h8FA8FFFC);
            check("seqC_a1", 32'(wq_addr[1]), 32'h084);
        end
        check("seqC_wcount", 32'(word_count), 32'd2);
        tick();

        // Address wrap at top of the 10-bit byte space
        ori = vt[7];
        clear_q();
        do_start(10'h3FC);
        send(vt[0], 1'b0);
        send(ori, 1'b1);
        wait_done("seqD_done");
        check("seqD_nwrites", 32'(wq_data.size()), 32'd2);
        if (wq_data.size() >= 2) begin
            check("seqD_a0", 32'(wq_addr[0]), 32'h3FC);
            check("seqD_a1", 32'(wq_addr[1]), 32'h000);
            check("seqD_d1", wq_data[1], 32'h37FFABCD);
        end
        tick();

        // Reset mid-stream discards buffered words
        clear_q();
        mem_ready = 1'b0;
        do_start(10'h020);
        send(vt[1], 1'b0);
        send(vt[3], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("seqE_valid", 32'(mem_valid), 32'd0);
        check("seqE_busy", 32'(busy), 32'd0);
        check("seqE_ready", 32'(in_ready), 32'd0);
        check("seqE_wcount", 32'(word_count), 32'd0);
        check("seqE_addr", 32'(mem_addr), 32'd0);
        tick();
        mem_ready = 1'b1;
        clear_q();
        do_start(10'h000);
        send(vt[4], 1'b1);
        wait_done("seqE_done");
        check("seqE_nwrites", 32'(wq_data.size()), 32'd1);
        if (wq_data.size() >= 1) check("seqE_d0", wq_data[0], 32'h3C041234);
        check("seqE_wcount2", 32'(word_count), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
